// File: rtl/gng_mul_arbiter_pkg.sv
// gng_mul_arb_defs: shared widths and latency for the multiplier arbiter.
package gng_mul_arb_defs;
    localparam int A_W     = 16;
    localparam int B_W     = 18;
    localparam int P_W     = 34;
    localparam int MUL_LAT = 2;
    localparam int STAT_W  = 16;
    typedef logic signed [A_W-1:0] a_t;
    typedef logic signed [B_W-1:0] b_t;
    typedef logic signed [P_W-1:0] p_t;
endpackage

// File: rtl/gng_mul_arbiter_if.sv
// gng_mul_arbiter_if: request and result bus shared by the arbiter and its requesters.
interface gng_mul_arbiter_if
    import gng_mul_arb_defs::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) ();
    logic                   hold;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*A_W-1:0]   req_a;
    logic [N_REQ*B_W-1:0]   req_b;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    p_t                     res_p;
    modport master (output hold, req_valid, req_a, req_b, input req_ready, res_valid, res_id, res_p);
    modport slave  (input hold, req_valid, req_a, req_b, output req_ready, res_valid, res_id, res_p);
endinterface

// File: rtl/gng_mul_arbiter_rr_pick.sv
// gng_rr_pick: combinational round-robin pick starting one past ptr.
module gng_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);
    logic [ID_W-1:0] j;
    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        j         = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = ID_W'((int'(ptr) + k) % N_REQ);
            if (en && req[j]) begin
                grant_idx = j;
                grant_any = 1'b1;
            end
        end
    end
    assign grant = grant_any ? N_REQ'(1) << grant_idx : '0;
endmodule

// File: rtl/gng_smul_16_18.sv
// gng_smul_16_18: signed 16x18 multiplier with registered inputs and product.
module gng_smul_16_18
    import gng_mul_arb_defs::*;
(
    input  logic clk,
    input  a_t   a,
    input  b_t   b,
    output p_t   p
);
    a_t a_r;
    b_t b_r;
    always_ff @(posedge clk) begin
        a_r <= a;
        b_r <= b;
        p   <= P_W'(a_r) * P_W'(b_r);
    end
endmodule

// File: rtl/gng_mul_arbiter.sv
// gng_mul_arbiter: round-robin share of one 16x18 multiplier, tagged results at fixed latency.
// Optional per-requester grant counters with GNG_MUL_ARB_STATS_EN.
module gng_mul_arbiter
    import gng_mul_arb_defs::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
`ifdef GNG_MUL_ARB_STATS_EN
    input  logic                      stat_clr,
    output logic [N_REQ*STAT_W-1:0]   stat_cnt,
`endif
    gng_mul_arbiter_if.slave          bus
);
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [N_REQ-1:0] grant;
    logic             grant_any;
    a_t               a_sel;
    b_t               b_sel;
    logic [MUL_LAT-1:0] tag_v;
    logic [ID_W-1:0]    tag_id [MUL_LAT];

    gng_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .en        (rstn & ~bus.hold),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );
    assign bus.req_ready = grant;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                a_sel = bus.req_a[i*A_W +: A_W];
                b_sel = bus.req_b[i*B_W +: B_W];
            end
        end
    end

    gng_smul_16_18 u_mul (
        .clk (clk),
        .a   (a_sel),
        .b   (b_sel),
        .p   (bus.res_p)
    );

    // Tags march alongside the multiplier's operand and product registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr <= ID_W'(N_REQ - 1);
            tag_v  <= '0;
            for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
        end else begin
            if (grant_any) rr_ptr <= grant_idx;
            tag_v     <= {tag_v[MUL_LAT-2:0], grant_any};
            tag_id[0] <= grant_idx;
            for (int i = 1; i < MUL_LAT; i++) tag_id[i] <= tag_id[i-1];
        end
    end
    // Masking with rstn keeps a result already in flight from leaking out during reset.
    assign bus.res_valid = tag_v[MUL_LAT-1] & rstn;
    assign bus.res_id    = tag_id[MUL_LAT-1];

`ifdef GNG_MUL_ARB_STATS_EN
    logic [STAT_W-1:0] cnt [N_REQ];
    always_ff @(posedge clk) begin
        if (!rstn || stat_clr) begin
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (grant[i] && cnt[i] != '1) cnt[i] <= cnt[i] + STAT_W'(1);
        end
    end
    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_cnt[g*STAT_W +: STAT_W] = cnt[g];
    end
`endif
endmodule
